// File: rtl/sv_bus_stream_demux.sv
// Stream-to-bus demultiplexer: reassembles LSB-first address/data byte frames into parallel bus transfers.
// Optional trailing XOR checksum byte enabled by defining SV_BUS_STREAM_DEMUX_CHK_EN.
module sv_bus_stream_demux #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sti_vld,
  input  logic [BW-1:0] sti_bus,
  output logic          sti_rdy,
  output logic          bso_vld,
  output logic [AW-1:0] bso_adr,
  output logic [DW-1:0] bso_dat,
  input  logic          bso_rdy,
  output logic          err
);

  localparam int FL = (AW + DW) / BW;
`ifdef SV_BUS_STREAM_DEMUX_CHK_EN
  localparam int FN = FL + 1;
`else
  localparam int FN = FL;
`endif
  localparam int CW = $clog2(FN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FN - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW+DW-1:0] asm_reg;
  logic [AW+DW-1:0] frame;
  logic             xfer;
  logic             match;
`ifdef SV_BUS_STREAM_DEMUX_CHK_EN
  logic [BW-1:0]    sum;
`endif

  assign xfer    = sti_vld & sti_rdy;
  assign sti_rdy = (cnt != LAST_IDX) | !bso_vld | bso_rdy;

  // The final byte bypasses the assembly register so the frame loads on its own transfer edge
`ifdef SV_BUS_STREAM_DEMUX_CHK_EN
  assign frame = asm_reg;
  assign match = ((sum ^ sti_bus) == '0);
`else
  assign frame = {sti_bus, asm_reg[AW+DW-BW-1:0]};
  assign match = 1'b1;
`endif

  // Byte collection, frame wrap and output register handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COLLECT;
      cnt     <= '0;
      asm_reg <= '0;
      bso_vld <= 1'b0;
      bso_adr <= '0;
      bso_dat <= '0;
      err     <= 1'b0;
`ifdef SV_BUS_STREAM_DEMUX_CHK_EN
      sum     <= '0;
`endif
    end else begin
      err <= 1'b0;
      if (bso_vld && bso_rdy) begin
        bso_vld <= 1'b0;
      end
      if (xfer) begin
        for (int i = 0; i < FL; i++) begin
          if (cnt == CW'(i)) begin
            asm_reg[i*BW +: BW] <= sti_bus;
          end
        end
        if (state == LAST) begin
          state <= COLLECT;
          cnt   <= '0;
`ifdef SV_BUS_STREAM_DEMUX_CHK_EN
          sum   <= '0;
`endif
          if (match) begin
            bso_vld <= 1'b1;
            bso_adr <= frame[AW-1:0];
            bso_dat <= frame[AW+DW-1:AW];
          end else begin
            err <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
`ifdef SV_BUS_STREAM_DEMUX_CHK_EN
          sum <= sum ^ sti_bus;
`endif
          if (cnt == LAST_IDX - CW'(1)) begin
            state <= LAST;
          end else begin
            state <= COLLECT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sv_bus_stream_demux.sv
// Directed self-checking bench for sv_bus_stream_demux with a scoreboard of expected bus transfers.
module tb_sv_bus_stream_demux;

`ifdef SV_BUS_STREAM_DEMUX_CHK_EN
  localparam int NBYTES = 9;
`else
  localparam int NBYTES = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sti_vld;
  logic [7:0]  sti_bus;
  logic        sti_rdy;
  logic        bso_vld;
  logic [31:0] bso_adr;
  logic [31:0] bso_dat;
  logic        bso_rdy;
  logic        err;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          err_cnt = 0;
  logic [63:0] exp_q[$];
  int          xcyc_q[$];
  logic [63:0] mon_e;
  logic [63:0] frames[10];

  sv_bus_stream_demux #(.AW(32), .DW(32), .BW(8)) dut (
    .clk(clk), .rst(rst),
    .sti_vld(sti_vld), .sti_bus(sti_bus), .sti_rdy(sti_rdy),
    .bso_vld(bso_vld), .bso_adr(bso_adr), .bso_dat(bso_dat),
    .bso_rdy(bso_rdy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare every bus transfer against the oldest expected frame
  always @(negedge clk) begin
    #2;
    if (!rst && bso_vld === 1'b1 && bso_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_xfer", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("bso_adr", {32'd0, bso_adr}, {32'd0, mon_e[31:0]});
        check_eq("bso_dat", {32'd0, bso_dat}, {32'd0, mon_e[63:32]});
      end
      xcyc_q.push_back(cyc);
    end
    if (!rst && err === 1'b1) err_cnt++;
  end

  function automatic logic [7:0] fbyte(input logic [63:0] f, input int i, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    if (i < 8) return f[8*i +: 8];
    for (int j = 0; j < 8; j++) x = x ^ f[8*j +: 8];
    if (corrupt) x[0] = ~x[0];
    return x;
  endfunction

  task automatic idle();
    @(negedge clk);
    sti_vld = 1'b0;
    sti_bus = 8'bx;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = 0;
      while ($urandom_range(0, 9) >= 3 && n < 20) begin
        idle();
        n++;
      end
    end
    @(negedge clk);
    sti_vld = 1'b1;
    sti_bus = b;
    #1;
    n = 0;
    while (!sti_rdy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!sti_rdy) check_eq("sti_rdy_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [63:0] f, input bit gaps, input bit corrupt);
    if (!corrupt) exp_q.push_back(f);
    for (int i = 0; i < NBYTES; i++) send_byte(fbyte(f, i, corrupt), gaps);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    sti_vld = 1'b0;
    sti_bus = 8'bx;
    bso_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_bso_vld", 64'(bso_vld), 64'd0);
    check_eq("rst_bso_adr", 64'(bso_adr), 64'd0);
    check_eq("rst_bso_dat", 64'(bso_dat), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_sti_rdy", 64'(sti_rdy), 64'd1);

    // Single frame: 78 56 34 12 EF BE AD DE
    send_frame({32'hDEADBEEF, 32'h12345678}, 1'b0, 1'b0);
    #1;
    check_eq("single_vld", 64'(bso_vld), 64'd1);
    check_eq("single_adr", 64'(bso_adr), 64'h12345678);
    check_eq("single_dat", 64'(bso_dat), 64'hDEADBEEF);
    idle();
    @(posedge clk);
    #1;
    check_eq("single_vld_drop", 64'(bso_vld), 64'd0);
    wait_drain("single_drain");

    // Backpressure: frame 1 held, frame 2 last byte stalled
    @(negedge clk);
    bso_rdy = 1'b0;
    send_frame({32'hA1A2A3A4, 32'hB1B2B3B4}, 1'b0, 1'b0);
    exp_q.push_back({32'hC1C2C3C4, 32'hD1D2D3D4});
    for (int i = 0; i < NBYTES - 1; i++) send_byte(fbyte({32'hC1C2C3C4, 32'hD1D2D3D4}, i, 1'b0), 1'b0);
    @(negedge clk);
    sti_vld = 1'b1;
    sti_bus = fbyte({32'hC1C2C3C4, 32'hD1D2D3D4}, NBYTES - 1, 1'b0);
    #1;
    check_eq("bp_stall_rdy", 64'(sti_rdy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("bp_hold_vld", 64'(bso_vld), 64'd1);
      check_eq("bp_hold_adr", 64'(bso_adr), 64'hB1B2B3B4);
      check_eq("bp_hold_dat", 64'(bso_dat), 64'hA1A2A3A4);
      check_eq("bp_hold_rdy", 64'(sti_rdy), 64'd0);
    end
    bso_rdy = 1'b1;
    #1;
    check_eq("bp_release_rdy", 64'(sti_rdy), 64'd1);
    @(posedge clk);
    #1;
    check_eq("bp_overlap_vld", 64'(bso_vld), 64'd1);
    check_eq("bp_overlap_adr", 64'(bso_adr), 64'hD1D2D3D4);
    idle();
    wait_drain("bp_drain");

    // Back-to-back random frames, no gaps
    for (int i = 0; i < 10; i++) frames[i] = {$urandom(), $urandom()};
    repeat (2) @(posedge clk);
    xcyc_q.delete();
    for (int i = 0; i < 10; i++) send_frame(frames[i], 1'b0, 1'b0);
    idle();
    wait_drain("b2b_drain");
    repeat (2) @(posedge clk);
    check_eq("b2b_count", 64'(xcyc_q.size()), 64'd10);
    for (int i = 1; i < xcyc_q.size(); i++)
      check_eq("b2b_spacing", 64'(xcyc_q[i] - xcyc_q[i-1]), 64'(NBYTES));

    // Same frames with ~30% valid duty
    xcyc_q.delete();
    for (int i = 0; i < 10; i++) send_frame(frames[i], 1'b1, 1'b0);
    idle();
    wait_drain("gap_drain");
    repeat (2) @(posedge clk);
    check_eq("gap_count", 64'(xcyc_q.size()), 64'd10);

    // Reset after three bytes of a frame that is then abandoned
    xcyc_q.delete();
    for (int i = 0; i < 3; i++) send_byte(fbyte(64'hFFEE_DDCC_BBAA_9988, i, 1'b0), 1'b0);
    @(negedge clk);
    sti_vld = 1'b0;
    sti_bus = 8'bx;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_vld", 64'(bso_vld), 64'd0);
    check_eq("midrst_rdy", 64'(sti_rdy), 64'd1);
    send_frame({32'h0BAD_F00D, 32'h0000_1234}, 1'b0, 1'b0);
    idle();
    wait_drain("midrst_drain");
    repeat (2) @(posedge clk);
    check_eq("midrst_count", 64'(xcyc_q.size()), 64'd1);

`ifdef SV_BUS_STREAM_DEMUX_CHK_EN
    xcyc_q.delete();
    send_frame({32'h1111_2222, 32'h3333_4444}, 1'b0, 1'b0);
    idle();
    wait_drain("chk_ok1_drain");
    send_frame({32'h5555_6666, 32'h7777_8888}, 1'b0, 1'b1);
    #1;
    check_eq("chk_err_pulse", 64'(err), 64'd1);
    check_eq("chk_err_novld", 64'(bso_vld), 64'd0);
    idle();
    @(posedge clk);
    #1;
    check_eq("chk_err_clear", 64'(err), 64'd0);
    send_frame({32'h9999_AAAA, 32'hBBBB_CCCC}, 1'b0, 1'b0);
    idle();
    wait_drain("chk_ok3_drain");
    repeat (2) @(posedge clk);
    check_eq("chk_xfer_count", 64'(xcyc_q.size()), 64'd2);
    check_eq("chk_err_count", 64'(err_cnt), 64'd1);
`else
    check_eq("err_never", 64'(err_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sv_bus_stream_demux.md
Name: sv_bus_stream_demux

Overview:
- Stream-to-bus demultiplexer: receives a byte stream of address/data frames and reassembles each frame into one parallel bus transfer.
- Counterpart (receiver) of the bus-to-stream mux; sits in the wrap between the stream input (sti_*) and the output bus (bso_*).
- Both sides use the vld/rdy handshake: a transfer occurs only on a clk edge where vld & rdy are both high.

Parameters:
- AW, 32, address width in bits; must be a multiple of BW.
- DW, 32, data width in bits; must be a multiple of BW.
- BW, 8, stream byte width in bits.
- Derived FL = (AW+DW)/BW, frame length in bytes (8 at defaults); not overridable.

Ports:
- clk      input   1    system clock, all logic on posedge
- rst      input   1    reset, synchronous, active-high
- sti_vld  input   1    stream byte valid
- sti_bus  input   BW   stream byte
- sti_rdy  output  1    stream byte ready
- bso_vld  output  1    bus transfer valid
- bso_adr  output  AW   bus address
- bso_dat  output  DW   bus data
- bso_rdy  input   1    bus ready
- err      output  1    one-cycle frame-error pulse; tied 0 unless the optional feature is enabled

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: bso_vld=0, bso_adr=0, bso_dat=0, err=0, byte counter cnt=0, assembly register=0. sti_rdy=1 in the first cycle after reset.
- Frame format:
  - Bytes 0..AW/BW-1 carry the address, least-significant byte first.
  - The following DW/BW bytes carry the data, least-significant byte first.
- Assembly state machine:
  - States: COLLECT (cnt 0..FL-2) and LAST (cnt=FL-1).
  - Each stream transfer (sti_vld & sti_rdy) writes sti_bus into byte slot cnt of the assembly register and increments cnt.
  - The transfer of the last byte wraps cnt to 0.
- Output register load:
  - On the last-byte transfer, bso_adr and bso_dat load the complete frame, with the last byte taken directly from sti_bus.
  - bso_vld goes to 1 on the next edge. Latency from last-byte transfer to bso_vld=1 is 1 cycle.
- Output hold:
  - bso_vld, bso_adr and bso_dat stay stable while bso_vld & !bso_rdy.
  - bso_vld clears after a bus transfer unless a new frame loads on the same edge.
- Ready rule: sti_rdy = (cnt != FL-1) | !bso_vld | bso_rdy.
  - Bytes 0..FL-2 are always accepted.
  - The last byte is accepted only if the output register is empty or draining in the same cycle.
- Throughput: back-to-back frames with no gaps give one bus transfer every FL cycles, with no bubble.
- Simultaneous events: a bus transfer and a new frame load on the same edge leave bso_vld=1 with the new contents.
- sti_vld gaps: idle cycles in the stream hold cnt and the assembly register unchanged; a frame may be spread over any number of cycles.
- Reset mid-frame: all partial state is discarded and cnt=0. The next byte after reset is treated as byte 0 of a new frame.
- Unknown values: X on sti_bus while sti_vld=0 must not propagate into any register.

Optional Feature:
- Macro: SV_BUS_STREAM_DEMUX_CHK_EN.
- When defined:
  - Frame length is FL+1. The extra final byte is the XOR of all FL preceding bytes.
  - The ready rule applies to this checksum byte instead of byte FL-1.
  - On checksum-byte transfer with a match: the frame loads exactly as above.
  - On a mismatch: the frame is dropped, bso_* are unchanged, and err=1 for exactly one cycle on the next edge.
- When undefined: FL-byte frames, no checksum logic, err constantly 0.

Test Plan:
- Single frame: bytes 78 56 34 12 EF BE AD DE with bso_rdy=1. Expect bso_adr=32'h12345678 and bso_dat=32'hDEADBEEF, with bso_vld=1 exactly 1 cycle after the 8th byte and for 1 cycle.
- Backpressure: bso_rdy=0 while 2 frames stream in. Expect frame 1 held stable, 7 bytes of frame 2 accepted, then sti_rdy=0 at byte 8. Raising bso_rdy gives the two bus transfers in order with no loss.
- Back-to-back: 10 frames with random data, sti_vld=1 and bso_rdy=1 throughout. Expect 10 bus transfers spaced exactly 8 cycles apart, all values matching.
- Stream gaps: random sti_vld duty of 30%. Expect output identical to the gap-free case.
- Reset mid-frame: assert rst after 3 bytes, then send a full frame. Expect only the new frame on the bus, with no corruption from the partial frame.
- With CHK_EN, checksum:
  - Correct checksum on frame 1 → transfer.
  - Corrupted checksum (bit 0 flipped) on frame 2 → err pulse of 1 cycle, no bso_vld.
  - Frame 3 → received correctly.
